// File: rtl/muldiv_pkg.sv
// muldiv_pkg: ALUmode muldiv codes, FSM encoding and defaults
// shared by ALU control, hazard unit and the muldiv unit.
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 6;

  localparam logic [3:0] MD_MULT  = 4'b1000;
  localparam logic [3:0] MD_MULTU = 4'b1001;
  localparam logic [3:0] MD_DIV   = 4'b1010;
  localparam logic [3:0] MD_DIVU  = 4'b1011;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  function automatic logic is_md(input logic [3:0] m);
    return m[3:2] == 2'b10;
  endfunction

  function automatic logic md_signed(input logic [3:0] m);
    return ~m[0];
  endfunction

  function automatic logic md_div(input logic [3:0] m);
    return m[1];
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// muldiv_core: unsigned iteration datapath, shift-add multiply
// and restoring divide sharing one 2*WIDTH accumulator.
module muldiv_core
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] ld_lo,
  input  logic [WIDTH-1:0] ld_m,
  output logic [WIDTH-1:0] nxt_hi,
  output logic [WIDTH-1:0] nxt_lo
);

  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   m;
  logic               div_q;

  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     sh;
  logic [WIDTH+1:0]   sub;
  logic               ge;
  logic [WIDTH-1:0]   rem;
  logic [2*WIDTH-1:0] nxt;

  assign acc_hi = acc[2*WIDTH-1:WIDTH];
  assign acc_lo = acc[WIDTH-1:0];

  // Partial remainder stays below m, so a non-borrowing
  // difference always fits WIDTH bits.
  always_comb begin
    sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, m} : '0);
    sh  = {acc_hi, acc_lo[WIDTH-1]};
    sub = {1'b0, sh} - {2'b00, m};
    ge  = ~|sub[WIDTH+1:WIDTH];
    rem = ge ? sub[WIDTH-1:0] : sh[WIDTH-1:0];
    if (div_q)
      nxt = {rem, acc_lo[WIDTH-2:0], ge};
    else
      nxt = {sum, acc_lo[WIDTH-1:1]};
  end

  assign nxt_hi = nxt[2*WIDTH-1:WIDTH];
  assign nxt_lo = nxt[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      acc   <= '0;
      m     <= '0;
      div_q <= 1'b0;
    end else if (load) begin
      acc   <= {{WIDTH{1'b0}}, ld_lo};
      m     <= ld_m;
      div_q <= is_div;
    end else if (step) begin
      acc   <= nxt;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU into HI/LO with
// busy stall request, plus MTHI/MTLO write path.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       ALUmode,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             neg_lo;
  logic             neg_hi;
  logic             op_div;
  logic             op_dz;
  logic [WIDTH-1:0] op_rs;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic             accept;
  logic             sa;
  logic             sb;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             last;
  logic [WIDTH-1:0] c_hi;
  logic [WIDTH-1:0] c_lo;

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  assign accept = start && is_md(ALUmode) &&
                  (state == ST_IDLE || state == ST_FIN);

  assign sa    = md_signed(ALUmode) & rs_val[WIDTH-1];
  assign sb    = md_signed(ALUmode) & rt_val[WIDTH-1];
  assign mag_a = sa ? -rs_val : rs_val;
  assign mag_b = sb ? -rt_val : rt_val;
  assign last  = (state == ST_RUN) &&
                 (cnt == CNT_W'(WIDTH - 1));

  muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .reset  (reset),
    .load   (accept),
    .step   (state == ST_RUN),
    .is_div (md_div(ALUmode)),
    .ld_lo  (md_div(ALUmode) ? mag_a : mag_b),
    .ld_m   (md_div(ALUmode) ? mag_b : mag_a),
    .nxt_hi (c_hi),
    .nxt_lo (c_lo)
  );

  // Sign fix-up applied to the final iteration's output so HI/LO
  // land on the same edge that leaves RUN.
  always_comb begin
    prod = neg_lo ? -{c_hi, c_lo} : {c_hi, c_lo};
    quo  = neg_lo ? -c_lo : c_lo;
    rem  = neg_hi ? -c_hi : c_hi;
    if (op_div && op_dz) begin
      res_hi = op_rs;
      res_lo = '1;
    end else if (op_div) begin
      res_hi = rem;
      res_lo = quo;
    end else begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      op_div <= 1'b0;
      op_dz  <= 1'b0;
      op_rs  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (hi_we) hi_q <= wdata;
          if (lo_we) lo_q <= wdata;
          if (accept) state <= ST_RUN;
        end
        ST_RUN: begin
          cnt <= cnt + CNT_W'(1);
          if (last) begin
            state <= ST_FIN;
            hi_q  <= res_hi;
            lo_q  <= res_lo;
          end
        end
        ST_FIN: begin
          state <= accept ? ST_RUN : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
      if (accept) begin
        cnt    <= '0;
        neg_lo <= sa ^ sb;
        neg_hi <= sa;
        op_div <= md_div(ALUmode);
        op_dz  <= md_div(ALUmode) && (rt_val == '0);
        op_rs  <= rs_val;
      end
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_FIN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors for muldiv_unit with
// immediate-assertion checks and a pass/total summary.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  ALUmode;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .ALUmode (ALUmode),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .hi_we   (hi_we),
    .lo_we   (lo_we),
    .wdata   (wdata),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
  endtask

  // Called at a negedge; inj>0 pokes a rogue start + MTHI at
  // that cycle of the operation.
  task automatic run_op(input string tag,
                        input logic [3:0] mode,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] eh,
                        input logic [31:0] el,
                        input int inj);
    int   lat;
    logic gap;
    start   = 1'b1;
    ALUmode = mode;
    rs_val  = a;
    rt_val  = b;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    gap   = 1'b0;
    while (!done && lat < 100) begin
      if (!busy) gap = 1'b1;
      if (lat == inj) begin
        start   = 1'b1;
        ALUmode = MD_MULTU;
        rs_val  = 32'hFFFF_FFFF;
        rt_val  = 32'hFFFF_FFFF;
        hi_we   = 1'b1;
        wdata   = 32'hDEAD_BEEF;
      end
      @(negedge clk);
      start = 1'b0;
      hi_we = 1'b0;
      lat++;
    end
    if (!busy) gap = 1'b1;
    check({tag, " latency"}, 64'(lat), 64'd33);
    check({tag, " hi"}, {32'd0, hi}, {32'd0, eh});
    check({tag, " lo"}, {32'd0, lo}, {32'd0, el});
    check({tag, " busy gap"}, {63'd0, gap}, 64'd0);
    @(negedge clk);
    check({tag, " idle after"}, {62'd0, busy, done}, 64'd0);
  endtask

  initial begin
    int pulses;
    reset   = 1'b1;
    start   = 1'b0;
    hi_we   = 1'b0;
    lo_we   = 1'b0;
    ALUmode = 4'd0;
    rs_val  = '0;
    rt_val  = '0;
    wdata   = '0;
    repeat (2) @(negedge clk);
    check("reset busy/done", {62'd0, busy, done}, 64'd0);
    check("reset hi", {32'd0, hi}, 64'd0);
    check("reset lo", {32'd0, lo}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    lo_we = 1'b1;
    wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    lo_we = 1'b0;
    check("mtlo lo", {32'd0, lo}, 64'hA5A5_A5A5);
    check("mtlo hi", {32'd0, hi}, 64'd0);

    start   = 1'b1;
    ALUmode = 4'b0010;
    @(negedge clk);
    start = 1'b0;
    check("bad code busy", {63'd0, busy}, 64'd0);

    run_op("multu max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFFE, 32'h0000_0001, 0);
    run_op("mult -3x7", MD_MULT, 32'hFFFF_FFFD, 32'd7,
           32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
    run_op("div -7/2", MD_DIV, 32'hFFFF_FFF9, 32'd2,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    run_op("divu 100/7", MD_DIVU, 32'd100, 32'd7,
           32'd2, 32'd14, 0);
    run_op("divu /0", MD_DIVU, 32'h1234, 32'd0,
           32'h1234, 32'hFFFF_FFFF, 0);
    run_op("div ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
           32'd0, 32'h8000_0000, 0);
    run_op("div -5/0", MD_DIV, 32'hFFFF_FFFB, 32'd0,
           32'hFFFF_FFFB, 32'hFFFF_FFFF, 0);
    run_op("mult busy poke", MD_MULT, 32'd3, 32'd5,
           32'd0, 32'd15, 10);

    start   = 1'b1;
    ALUmode = MD_DIVU;
    rs_val  = 32'hFFFF_0000;
    rt_val  = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort busy/done", {62'd0, busy, done}, 64'd0);
    check("abort hi", {32'd0, hi}, 64'd0);
    check("abort lo", {32'd0, lo}, 64'd0);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    check("abort no done", 64'(pulses), 64'd0);

    run_op("multu 6x7", MD_MULTU, 32'd6, 32'd7,
           32'd0, 32'd42, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
